// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : reg_file_pkg
//  Brief   : Shared constants and clear-FSM state type for the register file.
//  Rev     : 1.0  initial release
// ============================================================================
package reg_file_pkg;

    localparam int c_DEF_DATA_W   = 32;
    localparam int c_DEF_NUM_REGS = 32;
    localparam int c_DEF_NUM_RD   = 2;
    localparam int c_DEF_BYPASS   = 1;
    localparam int c_DEF_ZERO_REG = 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ============================================================================
//  Module  : reg_file_mp_if
//  Brief   : Read/write/reserve/clear bus of the multi-port register file.
//  Rev     : 1.0  initial release
// ============================================================================
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = c_DEF_DATA_W,
    parameter int NUM_REGS = c_DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = c_DEF_NUM_RD
);
    logic [NUM_RD*ADDR_W-1:0] Read_Reg;
    logic [NUM_RD*DATA_W-1:0] ReadData;
    logic [1:0]               RegWrite;
    logic [2*ADDR_W-1:0]      Write_Reg;
    logic [2*DATA_W-1:0]      Write_Data;
    logic                     Reserve_En;
    logic [ADDR_W-1:0]        Reserve_Reg;
    logic [NUM_RD-1:0]        Busy;
    logic                     Clear_Start;
    logic                     Clear_Busy;

    modport slave (
        input  Read_Reg, RegWrite, Write_Reg, Write_Data,
               Reserve_En, Reserve_Reg, Clear_Start,
        output ReadData, Busy, Clear_Busy
    );

    modport master (
        output Read_Reg, RegWrite, Write_Reg, Write_Data,
               Reserve_En, Reserve_Reg, Clear_Start,
        input  ReadData, Busy, Clear_Busy
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module  : reg_file_scoreboard
//  Brief   : Per-register pending bits with per-read-port busy lookup.
//  Rev     : 1.0  initial release
// ============================================================================
module reg_file_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     i_clr_all,
    input  wire logic [NUM_REGS-1:0]      i_set_vec,
    input  wire logic [NUM_REGS-1:0]      i_clr_vec,
    input  wire logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    input  wire logic [NUM_RD-1:0]        i_fwd_hit,
    output logic      [NUM_RD-1:0]        o_busy
);
    logic [NUM_REGS-1:0] r_sb;

    // Set is OR-ed after the clear so a reserve+write pair leaves the bit set.
    always_ff @(posedge clk) begin
        if (reset || i_clr_all) begin
            r_sb <= '0;
        end else begin
            r_sb <= (r_sb & ~i_clr_vec) | i_set_vec;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_busy
        assign o_busy[p] = r_sb[i_rd_addr[p*ADDR_W +: ADDR_W]] & ~i_fwd_hit[p];
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module  : reg_file_mp
//  Brief   : Multi-read / dual-write register file with forwarding,
//            pending-register scoreboard and a sequential clear sweep.
//  Rev     : 1.0  initial release
// ============================================================================
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = c_DEF_DATA_W,
    parameter int NUM_REGS = c_DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = c_DEF_NUM_RD,
    parameter int BYPASS   = c_DEF_BYPASS,
    parameter int ZERO_REG = c_DEF_ZERO_REG
) (
    input  wire logic     clk,
    input  wire logic     reset,
    reg_file_mp_if.slave  bus
);
    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    clr_state_t          r_state;
    clr_state_t          w_state_next;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   w_idx_next;
    logic                w_idle;
    logic                w_clr_all;
    logic [ADDR_W-1:0]   w_wa [2];
    logic [DATA_W-1:0]   w_wd [2];
    logic [1:0]          w_we;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_RD-1:0]   w_fwd_hit;
    logic [DATA_W-1:0]   w_rd_data [NUM_RD];

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign w_idle         = (r_state == ST_IDLE);
    assign bus.Clear_Busy = (r_state == ST_CLEAR);

    // Effective write enables: external writes only count while idle.
    for (genvar k = 0; k < 2; k++) begin : g_wr
        assign w_wa[k] = bus.Write_Reg[k*ADDR_W +: ADDR_W];
        assign w_wd[k] = bus.Write_Data[k*DATA_W +: DATA_W];
        assign w_we[k] = bus.RegWrite[k] && w_idle && !is_zero_reg(w_wa[k]);
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_clr_all    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.Clear_Start) begin
                    w_state_next = ST_CLEAR;
                    w_idx_next   = '0;
                    w_clr_all    = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (r_idx == c_LAST_IDX) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Port 1 is applied last so it wins a same-register collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_regs[r_idx] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_we[k]) begin
                    r_regs[w_wa[k]] <= w_wd[k];
                end
            end
        end
    end

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_idle && bus.Reserve_En && !is_zero_reg(bus.Reserve_Reg)) begin
            w_set[bus.Reserve_Reg] = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            if (w_we[k]) begin
                w_clr[w_wa[k]] = 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_hit0;
        logic              w_hit1;

        assign w_ra   = bus.Read_Reg[p*ADDR_W +: ADDR_W];
        assign w_hit0 = (BYPASS != 0) && w_we[0] && (w_wa[0] == w_ra);
        assign w_hit1 = (BYPASS != 0) && w_we[1] && (w_wa[1] == w_ra);
        assign w_fwd_hit[p] = w_hit0 | w_hit1;

        always_comb begin
            if (is_zero_reg(w_ra)) begin
                w_rd_data[p] = '0;
            end else if (w_hit1) begin
                w_rd_data[p] = w_wd[1];
            end else if (w_hit0) begin
                w_rd_data[p] = w_wd[0];
            end else begin
                w_rd_data[p] = r_regs[w_ra];
            end
        end
    end

    always_comb begin
        bus.ReadData = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            bus.ReadData[p*DATA_W +: DATA_W] = w_rd_data[p];
        end
    end

    reg_file_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .i_clr_all (w_clr_all),
        .i_set_vec (w_set),
        .i_clr_vec (w_clr),
        .i_rd_addr (bus.Read_Reg),
        .i_fwd_hit (w_fwd_hit),
        .o_busy    (bus.Busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module  : tb_reg_file_mp
//  Brief   : Self-checking bench for reg_file_mp (default parameters).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_reg_file_mp;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2)) bus ();

    reg_file_mp #(
        .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_cb;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic        cb;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        re;
        logic [4:0]  rr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
    } vec_t;
    vec_t vecs[17];

    logic [31:0] m_regs [NR];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic re, input logic [4:0] rr,
                         input logic [4:0] ra0, input logic [4:0] ra1, input logic cs);
        bus.RegWrite    = we;
        bus.Write_Reg   = {wa1, wa0};
        bus.Write_Data  = {wd1, wd0};
        bus.Reserve_En  = re;
        bus.Reserve_Reg = rr;
        bus.Read_Reg    = {ra1, ra0};
        bus.Clear_Start = cs;
    endtask

    task automatic push_exp(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [1:0] busy, input logic cb);
        exp_t e;
        e.d0 = d0; e.d1 = d1; e.busy = busy; e.cb = cb;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no expected entry queued", tag);
        end else begin
            e = exp_q.pop_front();
            cmp({tag, ".d0"},   bus.ReadData[31:0],  e.d0);
            cmp({tag, ".d1"},   bus.ReadData[63:32], e.d1);
            cmp({tag, ".busy"}, {30'd0, bus.Busy},   {30'd0, e.busy});
            cmp({tag, ".cb"},   {31'd0, bus.Clear_Busy}, {31'd0, e.cb});
        end
    endtask

    task automatic quiet_cycle(input logic [4:0] ra0, input logic [4:0] ra1);
        @(posedge clk); #1;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, ra0, ra1, 1'b0);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < NR / 2; i++) begin
            quiet_cycle(5'(2 * i), 5'(2 * i + 1));
            push_exp(32'h0, 32'h0, 2'b00, 1'b0);
            @(negedge clk);
            check_out($sformatf("%s_r%0d", tag, 2 * i));
        end
    endtask

    task automatic load_all(input logic [31:0] base);
        for (int i = 1; i < NR; i++) begin
            @(posedge clk); #1;
            drive(2'b01, 5'(i), base | 32'(i), 5'd0, 32'h0, (i == NR - 1), 5'd9, 5'd0, 5'd0, 1'b0);
            m_regs[i] = base | 32'(i);
        end
        m_regs[0] = 32'h0;
    endtask

    initial begin
        //              we     wa0    wd0         wa1    wd1         re    rr     ra0    ra1    e0          e1          eb
        vecs[0]  = '{2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 5'd0,  5'd10, 5'd11, 32'h0,      32'h0,      2'b00};
        vecs[1]  = '{2'b01, 5'd11, 32'd13,     5'd0,  32'h0,      1'b0, 5'd0,  5'd10, 5'd11, 32'h0,      32'd13,     2'b00};
        vecs[2]  = '{2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 5'd0,  5'd10, 5'd11, 32'h0,      32'd13,     2'b00};
        vecs[3]  = '{2'b11, 5'd5,  32'hAAAA,   5'd5,  32'h5555,   1'b0, 5'd0,  5'd5,  5'd11, 32'h5555,   32'd13,     2'b00};
        vecs[4]  = '{2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 5'd0,  5'd5,  5'd5,  32'h5555,   32'h5555,   2'b00};
        vecs[5]  = '{2'b01, 5'd0,  32'hFFFF,   5'd0,  32'h0,      1'b1, 5'd0,  5'd0,  5'd0,  32'h0,      32'h0,      2'b00};
        vecs[6]  = '{2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 5'd0,  5'd0,  5'd0,  32'h0,      32'h0,      2'b00};
        vecs[7]  = '{2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b1, 5'd7,  5'd7,  5'd5,  32'h0,      32'h5555,   2'b00};
        vecs[8]  = '{2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 5'd0,  5'd7,  5'd7,  32'h0,      32'h0,      2'b11};
        vecs[9]  = '{2'b10, 5'd0,  32'h0,      5'd7,  32'd9,      1'b0, 5'd0,  5'd7,  5'd5,  32'd9,      32'h5555,   2'b00};
        vecs[10] = '{2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 5'd0,  5'd7,  5'd7,  32'd9,      32'd9,      2'b00};
        vecs[11] = '{2'b01, 5'd7,  32'd21,     5'd0,  32'h0,      1'b1, 5'd7,  5'd7,  5'd11, 32'd21,     32'd13,     2'b00};
        vecs[12] = '{2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 5'd0,  5'd7,  5'd7,  32'd21,     32'd21,     2'b11};
        vecs[13] = '{2'b11, 5'd3,  32'h33,     5'd4,  32'h44,     1'b0, 5'd0,  5'd3,  5'd4,  32'h33,     32'h44,     2'b00};
        vecs[14] = '{2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 5'd0,  5'd3,  5'd4,  32'h33,     32'h44,     2'b00};
        vecs[15] = '{2'b01, 5'd7,  32'h77,     5'd0,  32'h0,      1'b0, 5'd0,  5'd3,  5'd7,  32'h33,     32'h77,     2'b00};
        vecs[16] = '{2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 5'd0,  5'd7,  5'd1,  32'h77,     32'h0,      2'b00};

        reset = 1'b1;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
                  vecs[i].re, vecs[i].rr, vecs[i].ra0, vecs[i].ra1, 1'b0);
            push_exp(vecs[i].e0, vecs[i].e1, vecs[i].eb, 1'b0);
            @(negedge clk);
            check_out($sformatf("vec%0d", i));
        end

        // Clear sweep: reg 9 reserved by the load, reg 10 reserved on the start edge.
        load_all(32'h1000_0000);
        @(posedge clk); #1;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd9, 5'd10, 1'b1);
        push_exp(m_regs[9], m_regs[10], 2'b01, 1'b0);
        @(negedge clk);
        check_out("start");

        n_cb = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (n_cb < NR)
                drive(2'b11, 5'd31, 32'hDEAD_0000, 5'd30, 32'hBEEF_0000, 1'b1, 5'd9,
                      (c == 0) ? 5'd31 : 5'd9, (c == 0) ? 5'd10 : 5'd5, (n_cb < 20));
            else
                drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            @(negedge clk);
            if (c == 0) begin
                push_exp(m_regs[31], m_regs[10], 2'b00, 1'b1);
                check_out("sweep0");
            end else if (c == 1) begin
                push_exp(m_regs[9], m_regs[5], 2'b00, 1'b1);
                check_out("sweep1");
            end
            if (bus.Clear_Busy) n_cb++;
            else break;
        end
        cmp("sweep_len", 32'(n_cb), 32'd32);
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
        read_all_zero("post_clear");

        // Reset during sweep cycle 10, with a write and reservation that must be lost.
        load_all(32'h2000_0000);
        @(posedge clk); #1;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        for (int c = 0; c < 10; c++) quiet_cycle(5'd0, 5'd0);
        @(posedge clk); #1;
        drive(2'b01, 5'd20, 32'h5A5A, 5'd0, 32'h0, 1'b1, 5'd21, 5'd0, 5'd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        cmp("rst_cycle_cb", {31'd0, bus.Clear_Busy}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd20, 5'd21, 1'b0);
        push_exp(32'h0, 32'h0, 2'b00, 1'b0);
        @(negedge clk);
        check_out("post_rst");
        read_all_zero("post_rst_all");

        @(posedge clk); #1;
        drive(2'b01, 5'd3, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        quiet_cycle(5'd3, 5'd20);
        push_exp(32'h1234, 32'h0, 2'b00, 1'b0);
        @(negedge clk);
        check_out("idle_write");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
